// File: rtl/game_pkg.sv
`default_nettype none
// game_pkg: cell, scan-code, state and direction encodings shared by the grid game controller.
package game_pkg;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] P1    = 2'd1;
    localparam logic [1:0] P2    = 2'd2;

    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_NEW   = 8'h2D;
    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;

    // Bit positions in the one-hot key vector.
    localparam int KEY_W   = 6;
    localparam int K_RIGHT = 0;
    localparam int K_LEFT  = 1;
    localparam int K_UP    = 2;
    localparam int K_DOWN  = 3;
    localparam int K_PLACE = 4;
    localparam int K_NEW   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLACE = 2'd1,
        ST_CHECK = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // Direction step table: 0 row, 1 column, 2 diagonal, 3 anti-diagonal.
    function automatic logic signed [4:0] dir_dr(input logic [1:0] d);
        return (d == 2'd0) ? 5'sd0 : 5'sd1;
    endfunction

    function automatic logic signed [4:0] dir_dc(input logic [1:0] d);
        case (d)
            2'd0:    return 5'sd1;
            2'd1:    return 5'sd0;
            2'd2:    return 5'sd1;
            default: return -5'sd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/grid_game_ctrl_scan_decoder.sv
`default_nettype none
// scan_decoder: tracks E0/F0 prefixes and turns completed make codes into a one-hot key strobe.
module scan_decoder
    import game_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid_i,
    output logic             key_valid_o,
    output logic [KEY_W-1:0] key_o
);

    logic ext_q;
    logic brk_q;
    logic is_pfx;

    assign is_pfx = (byte_i == PFX_EXT) || (byte_i == PFX_BRK);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (byte_valid_i) begin
            if (byte_i == PFX_EXT) begin
                ext_q <= 1'b1;
            end else if (byte_i == PFX_BRK) begin
                brk_q <= 1'b1;
            end else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    // Decoded combinationally so the top can act on the strobe cycle itself.
    always_comb begin
        key_o = '0;
        if (byte_valid_i && !is_pfx && !brk_q) begin
            if (ext_q) begin
                case (byte_i)
                    KEY_RIGHT: key_o[K_RIGHT] = 1'b1;
                    KEY_LEFT:  key_o[K_LEFT]  = 1'b1;
                    KEY_UP:    key_o[K_UP]    = 1'b1;
                    KEY_DOWN:  key_o[K_DOWN]  = 1'b1;
                    default:   key_o = '0;
                endcase
            end else begin
                case (byte_i)
                    KEY_SPACE, KEY_ENTER: key_o[K_PLACE] = 1'b1;
                    KEY_NEW:              key_o[K_NEW]   = 1'b1;
                    default:              key_o = '0;
                endcase
            end
        end
        key_valid_o = |key_o;
    end

endmodule
`default_nettype wire

// File: rtl/grid_game_ctrl.sv
`default_nettype none
// grid_game_ctrl: N x N grid game with PS/2 cursor control, occupancy checks and a
// sequential walk-based win/draw checker.
module grid_game_ctrl
    import game_pkg::*;
#(
    parameter int N       = 3,
    parameter int WIN_LEN = 3,
    parameter int ORIGIN  = 70,
    parameter int CELL_PX = 160
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [7:0]       iByte,
    input  logic             iByte_valid,
    output logic [9:0]       oCursor_x,
    output logic [9:0]       oCursor_y,
    output logic [2*N*N-1:0] oBoard,
    output logic [1:0]       oPlayer,
    output logic [1:0]       oWinner,
    output logic             oDraw,
    output logic             oBusy,
    output logic             oReject
);

    localparam int               CELLS = N * N;
    localparam logic [2:0]       LAST  = 3'(N - 1);
    localparam logic signed [4:0] NS   = 5'(N);

    logic             key_valid;
    logic [KEY_W-1:0] key;

    scan_decoder u_scan_decoder (
        .clk_i        (iCLK),
        .rst_i        (iRST),
        .byte_i       (iByte),
        .byte_valid_i (iByte_valid),
        .key_valid_o  (key_valid),
        .key_o        (key)
    );

    state_t            state_q;
    logic [2*CELLS-1:0] board_q;
    logic [1:0]        player_q, winner_q;
    logic              draw_q, busy_q, reject_q;
    logic [6:0]        moves_q;
    logic [2:0]        row_q, col_q, row_d, col_d, prow_q, pcol_q;
    logic [9:0]        x_q, y_q;
    logic [1:0]        dir_q;
    logic              fwd_q, resolve_q, win_q;
    logic [3:0]        run_q, run_inc;
    logic [2:0]        steps_q;
    logic signed [4:0] wr_q, wc_q, dr, dc, nr, nc, prow_s, pcol_s;
    logic              in_bounds, match, win_now, walk_end, occupied;
    int                cidx, tidx, pidx;

    // Cursor moves are dropped while busy; new game homes it from any state.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (key_valid && !busy_q) begin
            if (key[K_RIGHT]) col_d = (col_q == LAST) ? 3'd0 : col_q + 3'd1;
            if (key[K_LEFT])  col_d = (col_q == 3'd0) ? LAST : col_q - 3'd1;
            if (key[K_DOWN])  row_d = (row_q == LAST) ? 3'd0 : row_q + 3'd1;
            if (key[K_UP])    row_d = (row_q == 3'd0) ? LAST : row_q - 3'd1;
        end
        if (key_valid && key[K_NEW]) begin
            row_d = 3'd0;
            col_d = 3'd0;
        end
    end

    always_comb begin
        prow_s    = $signed({2'b00, prow_q});
        pcol_s    = $signed({2'b00, pcol_q});
        dr        = dir_dr(dir_q);
        dc        = dir_dc(dir_q);
        nr        = fwd_q ? wr_q + dr : wr_q - dr;
        nc        = fwd_q ? wc_q + dc : wc_q - dc;
        in_bounds = (nr >= 5'sd0) && (nr < NS) && (nc >= 5'sd0) && (nc < NS);
        cidx      = in_bounds ? int'(nr) * N + int'(nc) : 0;
        match     = in_bounds && (board_q[2*(CELLS-1-cidx) +: 2] == player_q);
        run_inc   = run_q + 4'd1;
        win_now   = match && (int'(run_inc) >= WIN_LEN);
        walk_end  = !match || (int'(steps_q) + 1 == WIN_LEN - 1);
        tidx      = int'(row_q) * N + int'(col_q);
        pidx      = int'(prow_q) * N + int'(pcol_q);
        occupied  = board_q[2*(CELLS-1-tidx) +: 2] != EMPTY;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            board_q   <= '0;
            player_q  <= P1;
            winner_q  <= EMPTY;
            draw_q    <= 1'b0;
            busy_q    <= 1'b0;
            reject_q  <= 1'b0;
            moves_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            x_q       <= 10'(ORIGIN);
            y_q       <= 10'(ORIGIN);
            prow_q    <= '0;
            pcol_q    <= '0;
            dir_q     <= '0;
            fwd_q     <= 1'b0;
            resolve_q <= 1'b0;
            win_q     <= 1'b0;
            run_q     <= 4'd1;
            steps_q   <= '0;
            wr_q      <= '0;
            wc_q      <= '0;
        end else begin
            reject_q <= 1'b0;
            row_q    <= row_d;
            col_q    <= col_d;
            x_q      <= 10'(ORIGIN + int'(col_d) * CELL_PX);
            y_q      <= 10'(ORIGIN + int'(row_d) * CELL_PX);
            if (key_valid && key[K_NEW]) begin
                state_q  <= ST_IDLE;
                board_q  <= '0;
                player_q <= P1;
                winner_q <= EMPTY;
                draw_q   <= 1'b0;
                busy_q   <= 1'b0;
                moves_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (key_valid && key[K_PLACE]) begin
                            if (occupied) begin
                                reject_q <= 1'b1;
                            end else begin
                                state_q <= ST_PLACE;
                                busy_q  <= 1'b1;
                                prow_q  <= row_q;
                                pcol_q  <= col_q;
                            end
                        end
                    end
                    ST_PLACE: begin
                        board_q[2*(CELLS-1-pidx) +: 2] <= player_q;
                        moves_q   <= moves_q + 7'd1;
                        state_q   <= ST_CHECK;
                        dir_q     <= 2'd0;
                        fwd_q     <= 1'b0;
                        run_q     <= 4'd1;
                        steps_q   <= '0;
                        wr_q      <= prow_s;
                        wc_q      <= pcol_s;
                        resolve_q <= 1'b0;
                        win_q     <= 1'b0;
                    end
                    ST_CHECK: begin
                        if (resolve_q) begin
                            busy_q <= 1'b0;
                            if (win_q) begin
                                winner_q <= player_q;
                                state_q  <= ST_OVER;
                            end else if (moves_q == 7'(CELLS)) begin
                                draw_q  <= 1'b1;
                                state_q <= ST_OVER;
                            end else begin
                                player_q <= (player_q == P1) ? P2 : P1;
                                state_q  <= ST_IDLE;
                            end
                        end else if (win_now) begin
                            win_q     <= 1'b1;
                            resolve_q <= 1'b1;
                        end else if (walk_end) begin
                            // Backward walk hands its run to the forward walk; forward end closes the direction.
                            wr_q    <= prow_s;
                            wc_q    <= pcol_s;
                            steps_q <= '0;
                            if (!fwd_q) begin
                                fwd_q <= 1'b1;
                                if (match) run_q <= run_inc;
                            end else begin
                                fwd_q <= 1'b0;
                                run_q <= 4'd1;
                                if (dir_q == 2'd3) resolve_q <= 1'b1;
                                else               dir_q     <= dir_q + 2'd1;
                            end
                        end else begin
                            run_q   <= run_inc;
                            steps_q <= steps_q + 3'd1;
                            wr_q    <= nr;
                            wc_q    <= nc;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign oCursor_x = x_q;
    assign oCursor_y = y_q;
    assign oBoard    = board_q;
    assign oPlayer   = player_q;
    assign oWinner   = winner_q;
    assign oDraw     = draw_q;
    assign oBusy     = busy_q;
    assign oReject   = reject_q;

endmodule
`default_nettype wire

// File: tb/tb_grid_game_ctrl.sv
`default_nettype none
// tb_grid_game_ctrl: scoreboard bench driving a 3x3 and a 5x5/WIN_LEN=4 controller with scan-code bytes.
module tb_grid_game_ctrl;

    localparam int S_X = 0, S_Y = 1, S_BOARD = 2, S_PLAYER = 3, S_WIN = 4, S_DRAW = 5, S_BUSY = 6, S_REJ = 7;

    typedef struct {
        string       tag;
        int          sig;
        logic [63:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bytev = 8'h00;
    logic       vld = 1'b0;
    int         sel = 0;
    logic       v0, v1;

    logic [9:0]  x0, y0, x1, y1;
    logic [17:0] b0;
    logic [49:0] b1;
    logic [1:0]  p0, w0, p1, w1;
    logic        d0, bz0, rj0, d1, bz1, rj1;

    exp_t sbq[$];
    int   n_vec = 0, n_err = 0;
    int   rc0 = 0, rc1 = 0;
    int   mrej[2] = '{0, 0};

    int   n, wl, mcr, mcc, mp, mw, md, mmoves;
    int   mb[64];

    always #5 clk = ~clk;

    assign v0 = vld && (sel == 0);
    assign v1 = vld && (sel == 1);

    grid_game_ctrl #(.N(3), .WIN_LEN(3), .ORIGIN(70), .CELL_PX(160)) dut3 (
        .iCLK(clk), .iRST(rst), .iByte(bytev), .iByte_valid(v0),
        .oCursor_x(x0), .oCursor_y(y0), .oBoard(b0), .oPlayer(p0), .oWinner(w0),
        .oDraw(d0), .oBusy(bz0), .oReject(rj0)
    );

    grid_game_ctrl #(.N(5), .WIN_LEN(4), .ORIGIN(70), .CELL_PX(160)) dut5 (
        .iCLK(clk), .iRST(rst), .iByte(bytev), .iByte_valid(v1),
        .oCursor_x(x1), .oCursor_y(y1), .oBoard(b1), .oPlayer(p1), .oWinner(w1),
        .oDraw(d1), .oBusy(bz1), .oReject(rj1)
    );

    always @(negedge clk) begin
        if (rj0) rc0++;
        if (rj1) rc1++;
    end

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] obs(input int s);
        case (s)
            S_X:      return (sel == 1) ? 64'(x1)  : 64'(x0);
            S_Y:      return (sel == 1) ? 64'(y1)  : 64'(y0);
            S_BOARD:  return (sel == 1) ? 64'(b1)  : 64'(b0);
            S_PLAYER: return (sel == 1) ? 64'(p1)  : 64'(p0);
            S_WIN:    return (sel == 1) ? 64'(w1)  : 64'(w0);
            S_DRAW:   return (sel == 1) ? 64'(d1)  : 64'(d0);
            S_BUSY:   return (sel == 1) ? 64'(bz1) : 64'(bz0);
            default:  return (sel == 1) ? 64'(rc1) : 64'(rc0);
        endcase
    endfunction

    function automatic logic [63:0] model_board();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n * n; i++) v[2*(n*n-1-i) +: 2] = 2'(mb[i]);
        return v;
    endfunction

    function automatic bit model_win(input int p);
        int dr[4];
        int dc[4];
        int rr, cc;
        bit ok;
        dr = '{0, 1, 1, 1};
        dc = '{1, 0, 1, -1};
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                for (int d = 0; d < 4; d++) begin
                    ok = 1'b1;
                    for (int k = 0; k < wl; k++) begin
                        rr = r + k * dr[d];
                        cc = c + k * dc[d];
                        if (rr < 0 || rr >= n || cc < 0 || cc >= n) ok = 1'b0;
                        else if (mb[rr*n+cc] != p) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
        return 1'b0;
    endfunction

    task automatic model_reset();
        n  = (sel == 1) ? 5 : 3;
        wl = (sel == 1) ? 4 : 3;
        mcr = 0; mcc = 0; mp = 1; mw = 0; md = 0; mmoves = 0;
        for (int i = 0; i < 64; i++) mb[i] = 0;
    endtask

    task automatic model_place();
        int i;
        i = mcr * n + mcc;
        if (mw != 0 || md != 0) return;
        if (mb[i] != 0) begin
            mrej[sel]++;
            return;
        end
        mb[i] = mp;
        mmoves++;
        if (model_win(mp)) mw = mp;
        else if (mmoves == n * n) md = 1;
        else mp = 3 - mp;
    endtask

    task automatic exp_state(input string pfx);
        sbq.push_back('{{pfx, ".x"},       S_X,      64'(70 + mcc * 160)});
        sbq.push_back('{{pfx, ".y"},       S_Y,      64'(70 + mcr * 160)});
        sbq.push_back('{{pfx, ".board"},   S_BOARD,  model_board()});
        sbq.push_back('{{pfx, ".player"},  S_PLAYER, 64'(mp)});
        sbq.push_back('{{pfx, ".winner"},  S_WIN,    64'(mw)});
        sbq.push_back('{{pfx, ".draw"},    S_DRAW,   64'(md)});
        sbq.push_back('{{pfx, ".busy"},    S_BUSY,   64'd0});
        sbq.push_back('{{pfx, ".rejects"}, S_REJ,    64'(mrej[sel])});
    endtask

    task automatic drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk_eq(e.tag, obs(e.sig), e.val);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bytev = b;
        vld   = 1'b1;
        @(negedge clk);
        vld   = 1'b0;
    endtask

    task automatic move(input logic [7:0] code);
        send(8'hE0);
        send(code);
        case (code)
            8'h74:   mcc = (mcc + 1) % n;
            8'h6B:   mcc = (mcc + n - 1) % n;
            8'h72:   mcr = (mcr + 1) % n;
            default: mcr = (mcr + n - 1) % n;
        endcase
    endtask

    task automatic goto(input int r, input int c);
        while (mcc != c) move(8'h74);
        while (mcr != r) move(8'h72);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 1;
        while (obs(S_BUSY) == 64'd1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 60) chk_eq("busy_timeout", obs(S_BUSY), 64'd0);
    endtask

    task automatic place_at(input int r, input int c, output int cyc);
        goto(r, c);
        send(8'h29);
        wait_idle(cyc);
        model_place();
    endtask

    task automatic new_game();
        send(8'h2D);
        model_reset();
    endtask

    initial begin
        int cyc;
        logic [63:0] bsnap;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        exp_state("reset");
        drain();

        // Cursor wrap and break handling.
        move(8'h6B);
        chk_eq("wrap_left_x", obs(S_X), 64'd390);
        send(8'hE0); send(8'hF0); send(8'h6B);
        exp_state("break_ignored");
        drain();
        move(8'h74); move(8'h74);
        chk_eq("right_twice_x", obs(S_X), 64'd230);
        move(8'h75);
        chk_eq("wrap_up_y", obs(S_Y), 64'd390);
        move(8'h72);
        exp_state("cursor");
        drain();

        // Placement latency and occupied-cell rejection.
        goto(0, 0);
        @(negedge clk); bytev = 8'h5A; vld = 1'b1;
        @(negedge clk); vld = 1'b0;
        chk_eq("place_not_yet", obs(S_BOARD), 64'd0);
        @(negedge clk);
        bsnap = obs(S_BOARD);
        chk_eq("place_cell0", 64'(bsnap[17:16]), 64'd1);
        wait_idle(cyc);
        model_place();
        chk_eq("player_after_place", obs(S_PLAYER), 64'd2);
        @(negedge clk); bytev = 8'h29; vld = 1'b1;
        @(negedge clk); vld = 1'b0;
        chk_eq("reject_pulse", 64'(rj0), 64'd1);
        @(negedge clk);
        chk_eq("reject_one_cycle", 64'(rj0), 64'd0);
        model_place();
        exp_state("occupied");
        drain();

        // Row win, then placement ignored in OVER while the cursor still moves.
        new_game();
        place_at(0, 0, cyc); place_at(1, 0, cyc); place_at(0, 1, cyc); place_at(1, 1, cyc);
        place_at(0, 2, cyc);
        chk_eq("row_win_latency_ok", 64'(cyc <= 9), 64'd1);
        chk_eq("row_winner", obs(S_WIN), 64'd1);
        exp_state("row_win");
        drain();
        place_at(2, 2, cyc);
        exp_state("over_ignored");
        drain();

        // Drawn game.
        new_game();
        place_at(0, 0, cyc); place_at(1, 1, cyc); place_at(0, 2, cyc); place_at(0, 1, cyc);
        place_at(2, 1, cyc); place_at(1, 2, cyc); place_at(1, 0, cyc); place_at(2, 0, cyc);
        place_at(2, 2, cyc);
        chk_eq("draw_flag", obs(S_DRAW), 64'd1);
        chk_eq("draw_winner", obs(S_WIN), 64'd0);
        exp_state("draw");
        drain();

        // New game issued mid-CHECK.
        new_game();
        goto(1, 1);
        send(8'h29);
        @(negedge clk);
        chk_eq("busy_in_check", obs(S_BUSY), 64'd1);
        new_game();
        exp_state("newgame_mid_check");
        drain();

        // iRST mid-game.
        place_at(1, 1, cyc);
        goto(2, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
        exp_state("irst_mid_game");
        drain();

        // 5x5, WIN_LEN=4 anti-diagonal completed from the middle of the line.
        sel = 1;
        model_reset();
        exp_state("n5_reset");
        drain();
        place_at(4, 4, cyc); place_at(0, 3, cyc); place_at(4, 2, cyc); place_at(2, 1, cyc);
        place_at(2, 4, cyc); place_at(3, 0, cyc); place_at(0, 0, cyc); place_at(1, 2, cyc);
        chk_eq("anti_winner", obs(S_WIN), 64'd2);
        exp_state("anti_diag");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
